// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, optional FWFT read and sticky errors.
// Latency: write to FWFT output visible 1 cycle after the write edge; standard read data 1 cycle after accepted read.
// Backpressure: writes rejected while full, reads rejected while empty; rejected requests set a sticky error flag.
module sync_fifo_flex #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_winc,
    input  logic [WIDTH-1:0]         i_data_in,
    input  logic                     i_rinc,
    input  logic                     i_clr_err,
    output logic [WIDTH-1:0]         o_data_out,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_afull,
    output logic                     o_aempty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_C  = (PTR_W+1)'(AFULL_TH);
    localparam logic [PTR_W:0] AEMPTY_C = (PTR_W+1)'(AEMPTY_TH);

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "sync_fifo_flex: DEPTH must be a power of 2 and >= 4");
        end
        if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
            $fatal(1, "sync_fifo_flex: AFULL_TH out of range 1..DEPTH");
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
            $fatal(1, "sync_fifo_flex: AEMPTY_TH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] head_dat;

    // Accept decisions use the registered flags, so no input reaches an output combinationally.
    always_comb begin
        wr_acc   = i_winc && !full_q;
        rd_acc   = i_rinc && !empty_q;
        head_dat = mem_q[rptr_q[PTR_W-1:0]];

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) wptr_d = wptr_q + PTR_ONE;
        if (rd_acc) rptr_d = rptr_q + PTR_ONE;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + PTR_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - PTR_ONE;
        end

        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);

        // Set beats clear when both happen in the same cycle.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (i_clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (i_winc && full_q)  ovf_d = 1'b1;
        if (i_rinc && empty_q) unf_d = 1'b1;

        dout_d = dout_q;
        if (FWFT == 0 && rd_acc) dout_d = head_dat;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem_q[wptr_q[PTR_W-1:0]] <= i_data_in;
    end

    // FWFT presents the head entry directly; it is forced to zero while empty so reset reads back 0.
    assign o_data_out  = (FWFT != 0) ? (empty_q ? '0 : head_dat) : dout_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_afull     = afull_q;
    assign o_aempty    = aempty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
